// File: rtl/shift_out_param.sv
// Parallel-to-serial output stage: captures a WIDTH-bit word on a rising
// edge of sz and emits it one bit per enabled clock, framed by fz, with a
// one-cycle done pulse after the last bit and a sticky overrun flag.
module shift_out_param #(
  parameter int WIDTH     = 24,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] z_parallel,
  input  logic             sz,
  input  logic             shift_en,
  output logic             z_out,
  output logic             fz,
  output logic             done,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   shifted;
  logic [CNT_W-1:0]   count;
  logic               sz_d;
  logic               start;
  logic               last;
  logic               load_bit;
  logic               shift_bit;

  assign start = sz & ~sz_d;
  assign last  = (count == CNT_W'(WIDTH - 1));

  // Next shift-register contents and the bit that lands on the output end
  always_comb begin
    shifted   = '0;
    load_bit  = 1'b0;
    shift_bit = 1'b0;
    if (LSB_FIRST) begin
      shifted   = {1'b0, shreg[WIDTH-1:1]};
      load_bit  = z_parallel[0];
      shift_bit = shifted[0];
    end else begin
      shifted   = {shreg[WIDTH-2:0], 1'b0};
      load_bit  = z_parallel[WIDTH-1];
      shift_bit = shifted[WIDTH-1];
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; DONE always leaves after one cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: if (shift_en && last) state_nxt = DONE;
      DONE:  state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; z_out mirrors the output end of shreg
  // one cycle ahead so it is valid in the same cycle fz rises
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      count   <= '0;
      sz_d    <= 1'b0;
      z_out   <= 1'b0;
      fz      <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sz_d <= sz;
      done <= 1'b0;
      if (state != SHIFT && start) begin
        shreg   <= z_parallel;
        count   <= '0;
        z_out   <= load_bit;
        fz      <= 1'b1;
        overrun <= 1'b0;
      end else if (state == SHIFT) begin
        if (start) overrun <= 1'b1;
        if (shift_en) begin
          if (last) begin
            shreg <= '0;
            z_out <= 1'b0;
            fz    <= 1'b0;
            done  <= 1'b1;
          end else begin
            shreg <= shifted;
            count <= count + CNT_W'(1);
            z_out <= shift_bit;
          end
        end
      end
    end
  end

endmodule
